// File: rtl/im_loader.sv
// im_loader: streams program bytes into instruction-memory words and holds the core in reset
// until a complete program has been written.
// Bytes are packed little-endian into IM_DATA_BYTES lanes. Each finished word is presented for
// one cycle on o_we_im/o_im_data. A final partial word is flushed with enables only on the
// filled lanes.
// Optional feature macro: IM_LOADER_CHKSUM_EN. When it is defined, the byte tagged with i_last
// is an 8-bit additive checksum of all data bytes. That byte is never written to memory.
module im_loader #(
   parameter int unsigned IM_DATA_BYTES = 4,
   parameter int unsigned MAX_WORDS     = 1024,
   localparam int unsigned CW = $clog2(MAX_WORDS) + 1,
   localparam int unsigned IW = (IM_DATA_BYTES > 1) ? $clog2(IM_DATA_BYTES) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_start,
   input  logic                       i_byte_valid,
   input  logic [7:0]                 i_byte,
   input  logic                       i_last,
   output logic                       o_byte_ready,
   output logic [IM_DATA_BYTES-1:0]   o_we_im,
   output logic [8*IM_DATA_BYTES-1:0] o_im_data,
   output logic                       o_core_rst_n,
   output logic                       o_done,
   output logic                       o_err,
   output logic [CW-1:0]              o_word_cnt
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

   state_e                       state_q;
   logic [IW-1:0]                idx_q;
   logic [8*IM_DATA_BYTES-1:0]   word_q;
   // fin_q marks the cycle of the final write; fin_ok_q selects DONE or ERR afterwards.
   logic                         fin_q;
   logic                         fin_ok_q;
`ifdef IM_LOADER_CHKSUM_EN
   logic [7:0]                   sum_q;
   logic                         chk_ok;
`endif

   logic                         accept;
   logic                         idx_wrap;
   logic                         at_max;
   logic [8*IM_DATA_BYTES-1:0]   merged;
   logic [IM_DATA_BYTES-1:0]     part_mask;

   // Byte handshake, lane merge and partial-word enable mask
   always_comb begin
      accept   = (state_q == StLoad) && !fin_q && o_byte_ready && i_byte_valid;
      idx_wrap = (idx_q == IW'(IM_DATA_BYTES - 1));
      at_max   = (o_word_cnt == CW'(MAX_WORDS));
      merged   = word_q;
      for (int l = 0; l < int'(IM_DATA_BYTES); l++) begin
         if (IW'(l) == idx_q) merged[l*8 +: 8] = i_byte;
      end
      part_mask = '0;
      for (int l = 0; l < int'(IM_DATA_BYTES); l++) begin
`ifdef IM_LOADER_CHKSUM_EN
         // The checksum byte occupies no lane, so only lanes below idx are filled.
         part_mask[l] = (IW'(l) < idx_q);
`else
         part_mask[l] = (IW'(l) <= idx_q);
`endif
      end
`ifdef IM_LOADER_CHKSUM_EN
      chk_ok = (sum_q == i_byte);
`endif
   end

   // Loader FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         word_q       <= '0;
         fin_q        <= 1'b0;
         fin_ok_q     <= 1'b0;
         o_byte_ready <= 1'b0;
         o_we_im      <= '0;
         o_im_data    <= '0;
         o_core_rst_n <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_word_cnt   <= '0;
`ifdef IM_LOADER_CHKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         // Write strobes last exactly one cycle.
         o_we_im   <= '0;
         o_im_data <= '0;
         case (state_q)
            StIdle, StDone, StErr: begin
               if (i_start) begin
                  state_q      <= StLoad;
                  idx_q        <= '0;
                  word_q       <= '0;
                  fin_q        <= 1'b0;
                  fin_ok_q     <= 1'b0;
                  o_byte_ready <= 1'b1;
                  o_core_rst_n <= 1'b0;
                  o_done       <= 1'b0;
                  o_err        <= 1'b0;
                  o_word_cnt   <= '0;
`ifdef IM_LOADER_CHKSUM_EN
                  sum_q        <= '0;
`endif
               end
            end
            StLoad: begin
               if (fin_q) begin
                  fin_q        <= 1'b0;
                  state_q      <= fin_ok_q ? StDone : StErr;
                  o_done       <= fin_ok_q;
                  o_err        <= !fin_ok_q;
                  o_core_rst_n <= fin_ok_q;
               end else if (accept) begin
`ifdef IM_LOADER_CHKSUM_EN
                  if (i_last) begin
                     o_byte_ready <= 1'b0;
                     if (idx_q == '0) begin
                        // Nothing left to flush, so the load ends on the next cycle.
                        state_q      <= chk_ok ? StDone : StErr;
                        o_done       <= chk_ok;
                        o_err        <= !chk_ok;
                        o_core_rst_n <= chk_ok;
                     end else if (at_max) begin
                        state_q <= StErr;
                        o_err   <= 1'b1;
                     end else begin
                        o_we_im    <= part_mask;
                        o_im_data  <= word_q;
                        o_word_cnt <= o_word_cnt + CW'(1);
                        fin_q      <= 1'b1;
                        fin_ok_q   <= chk_ok;
                     end
                  end else begin
                     sum_q  <= sum_q + i_byte;
                     word_q <= idx_wrap ? '0 : merged;
                     idx_q  <= idx_wrap ? '0 : idx_q + IW'(1);
                     if (idx_wrap) begin
                        if (at_max) begin
                           state_q      <= StErr;
                           o_err        <= 1'b1;
                           o_byte_ready <= 1'b0;
                        end else begin
                           o_we_im    <= '1;
                           o_im_data  <= merged;
                           o_word_cnt <= o_word_cnt + CW'(1);
                        end
                     end
                  end
`else
                  word_q <= idx_wrap ? '0 : merged;
                  idx_q  <= idx_wrap ? '0 : idx_q + IW'(1);
                  if ((idx_wrap || i_last) && at_max) begin
                     // No room for another word, so the write is dropped.
                     state_q      <= StErr;
                     o_err        <= 1'b1;
                     o_byte_ready <= 1'b0;
                  end else begin
                     if (idx_wrap || i_last) begin
                        o_we_im    <= idx_wrap ? '1 : part_mask;
                        o_im_data  <= merged;
                        o_word_cnt <= o_word_cnt + CW'(1);
                     end
                     if (i_last) begin
                        o_byte_ready <= 1'b0;
                        fin_q        <= 1'b1;
                        fin_ok_q     <= 1'b1;
                     end
                  end
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
